stream_mux_n: RTL and testbench

- Parametrised, registered successor to the 4:1 select mux. Adds N channels, configurable data width and a valid/ready handshake per channel.
- Two selection modes: fixed-select (external `sel`, like the classic mux) and round-robin arbitration across all requesting channels.
- Sits between several producer streams and one consumer. Output is a one-entry registered stage, so the consumer never sees a combinational path from inputs.

---
 rtl/stream_mux_pkg.sv | 30 +++
 rtl/stream_mux_n_rr_pick.sv | 27 ++
 rtl/stream_mux_n.sv | 97 +++++++++
 tb/tb_stream_mux_n.sv | 129 ++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants, output-stage state encoding and channel-slice helper
// for the stream_mux_n family.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest flattened data bus and widest per-channel slice the helper handles.
  localparam int BUS_MAX_W   = 1024;
  localparam int SLICE_MAX_W = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [SLICE_MAX_W-1:0] ch_slice(
    input logic [BUS_MAX_W-1:0] bus,
    input int                   idx,
    input int                   w
  );
    logic [BUS_MAX_W-1:0]   shifted;
    logic [SLICE_MAX_W-1:0] mask;
    shifted  = bus >> (idx * w);
    mask     = (w >= SLICE_MAX_W) ? {SLICE_MAX_W{1'b1}}
                                  : ((64'd1 << w) - 64'd1);
    ch_slice = shifted[SLICE_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// Rotating-priority encoder: first set bit of req at or after base, wrapping
// to 0. Purely combinational.
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Walk from the farthest candidate back to base so the closest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      int c;
      c = (int'(base) + i) % N_CH;
      if (req[c]) begin
        found = 1'b1;
        idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant
// and a one-entry registered output stage.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  out_state_e           state_q, state_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_ch_q, out_ch_d;
  logic [SEL_W-1:0]     last_grant_q, last_grant_d;

  logic [SEL_W-1:0]     rr_base, rr_idx, grant_idx;
  logic                 rr_found, grant_found;
  logic                 load_en, xfer;
  logic [BUS_MAX_W-1:0] data_ext;

  assign data_ext = BUS_MAX_W'(in_data);
  assign rr_base  = (last_grant_q == SEL_W'(N_CH - 1)) ? '0 : last_grant_q + 1'b1;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (in_valid),
    .base  (rr_base),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = sel;
    if (mode == MODE_RR) begin
      grant_found = rr_found;
      grant_idx   = rr_idx;
    end else begin
      // Out-of-range sel never grants, even if the addressed bit would exist.
      grant_found = (int'(sel) < N_CH) && in_valid[sel];
    end
  end

  assign load_en = (state_q == ST_EMPTY) || out_ready;
  assign xfer    = load_en && grant_found && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (load_en) state_d = grant_found ? ST_FULL : ST_EMPTY;
    if (xfer) begin
      out_data_d   = WIDTH'(ch_slice(data_ext, int'(grant_idx), WIDTH));
      out_ch_d     = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= SEL_W'(N_CH - 1);
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed scoreboard bench for stream_mux_n (N_CH=4, WIDTH=4).
module tb_stream_mux_n;

  localparam int N_CH  = 4;
  localparam int WIDTH = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  stream_mux_n #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the output register against the scoreboard head.
  task automatic chk_out(input string tag);
    chk({tag, ".ovld"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".odata"}, 32'(out_data), 32'(q[0].data));
      chk({tag, ".och"},   32'(out_ch),   32'(q[0].ch));
    end
  endtask

  task automatic rst_step(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".irdy"}, 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    q.delete();
    chk({tag, ".ovld"},  32'(out_valid), 32'h0);
    chk({tag, ".odata"}, 32'(out_data),  32'h0);
    chk({tag, ".och"},   32'(out_ch),    32'h0);
  endtask

  task automatic step(input string tag, input logic m, input logic [SEL_W-1:0] s,
                      input logic [N_CH-1:0] v, input logic ordy,
                      input logic [N_CH-1:0] exp_rdy);
    logic consumed;
    exp_t e;
    rst = 1'b0; mode = m; sel = s; in_valid = v; out_ready = ordy;
    #1;
    chk({tag, ".irdy"}, 32'(in_ready), 32'(exp_rdy));
    consumed = out_valid && out_ready;
    @(posedge clk); #1;
    if (consumed && q.size() != 0) void'(q.pop_front());
    if (exp_rdy != '0) begin
      e.ch = '0;
      for (int i = 0; i < N_CH; i++) if (exp_rdy[i]) e.ch = SEL_W'(i);
      e.data = in_data[int'(e.ch)*WIDTH +: WIDTH];
      q.push_back(e);
    end
    chk_out(tag);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 4'b1111;
    in_data = 16'hDCBA; out_ready = 1'b1;

    rst_step("rst0");
    rst_step("rst1");

    step("fix0", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step("fix1", 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010);
    step("fix2", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
    step("fix3", 1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000);
    step("fixnv0", 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000);
    step("fixnv1", 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000);

    rst_step("rst2");
    in_data = 16'h7E51;
    for (int k = 0; k < 8; k++)
      step($sformatf("rr4_%0d", k), 1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)));
    for (int k = 0; k < 4; k++)
      step($sformatf("rr13_%0d", k), 1'b1, 2'd0, 4'b1010, 1'b1,
           (k % 2 == 0) ? 4'b0010 : 4'b1000);

    for (int k = 0; k < 3; k++)
      step($sformatf("bp_%0d", k), 1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000);
    step("bprel", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010);

    step("rrmid", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    in_valid = 4'b1111;
    rst_step("rstmid");
    step("rrpost", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step("drain", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
